// File: rtl/ysyx_25020037_lsu_axi_master.sv
// Single-outstanding AXI4 initiator for the core load/store port, with byte-lane alignment.
// Define YSYX_25020037_AXI_TIMEOUT_EN to enable the response watchdog (TIMEOUT_CYCLES).
module ysyx_25020037_lsu_axi_master #(
   parameter logic [3:0] AXI_ID         = 4'h1,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [3:0]  awid,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,
   input  logic [3:0]  bid,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [1:0]  rresp,
   input  logic [31:0] rdata,
   input  logic        rlast,
   input  logic [3:0]  rid
);

   typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_t;

   state_t      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [3:0]  id_q;
   logic        req_ready_d, rsp_valid_d, rsp_err_d;
   logic [31:0] rsp_rdata_d;
   logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic [31:0] awaddr_d, araddr_d, wdata_d;
   logic [2:0]  awsize_d, arsize_d;
   logic [3:0]  wstrb_d;
   logic        timeout_hit;

   assign awid    = id_q;
   assign arid    = id_q;
   assign awlen   = 8'h00;
   assign arlen   = 8'h00;
   assign awburst = 2'b01;
   assign arburst = 2'b01;
   assign wlast   = wvalid;

`ifdef YSYX_25020037_AXI_TIMEOUT_EN
   logic [31:0] to_cnt;

   // Counter rests at zero in IDLE, so it is already cleared on entry to AR/AW_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if (state_q == IDLE) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 32'd1;
      end
   end

   assign timeout_hit = (state_q != IDLE) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata;
      awvalid_d   = awvalid;
      wvalid_d    = wvalid;
      bready_d    = bready;
      arvalid_d   = arvalid;
      rready_d    = rready;
      awaddr_d    = awaddr;
      araddr_d    = araddr;
      wdata_d     = wdata;
      awsize_d    = awsize;
      arsize_d    = arsize;
      wstrb_d     = wstrb;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               off_d = req_addr[1:0];
               if (req_we) begin
                  state_d   = AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = req_addr;
                  awsize_d  = {1'b0, req_size};
                  wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
                  wstrb_d   = req_wmask << req_addr[1:0];
               end else begin
                  state_d   = AR;
                  arvalid_d = 1'b1;
                  araddr_d  = req_addr;
                  arsize_d  = {1'b0, req_size};
               end
            end
         end
         AR: begin
            if (arvalid && arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = R;
            end
         end
         R: begin
            if (rvalid && rready) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = rdata >> {off_q, 3'b000};
               rsp_err_d   = (rresp != 2'b00) || (rid != AXI_ID) || !rlast;
               rready_d    = 1'b0;
               state_d     = IDLE;
            end
         end
         AW_W: begin
            // The two channels complete independently; B waits for whichever finishes last.
            if (awvalid && awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid && wready) begin
               wvalid_d = 1'b0;
            end
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = B;
            end
         end
         B: begin
            if (bvalid && bready) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = (bresp != 2'b00) || (bid != AXI_ID);
               bready_d    = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (timeout_hit) begin
         state_d     = IDLE;
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         bready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_rdata_d = '0;
      end
      // Hold off new requests during the response pulse so the two never coincide.
      req_ready_d = (state_d == IDLE) && !rsp_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         off_q     <= '0;
         id_q      <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         awaddr    <= '0;
         araddr    <= '0;
         wdata     <= '0;
         awsize    <= '0;
         arsize    <= '0;
         wstrb     <= '0;
      end else begin
         state_q   <= state_d;
         off_q     <= off_d;
         id_q      <= AXI_ID;
         req_ready <= req_ready_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_rdata <= rsp_rdata_d;
         awvalid   <= awvalid_d;
         wvalid    <= wvalid_d;
         bready    <= bready_d;
         arvalid   <= arvalid_d;
         rready    <= rready_d;
         awaddr    <= awaddr_d;
         araddr    <= araddr_d;
         wdata     <= wdata_d;
         awsize    <= awsize_d;
         arsize    <= arsize_d;
         wstrb     <= wstrb_d;
      end
   end

endmodule

// File: tb/tb_ysyx_25020037_lsu_axi_master.sv
// Randomized self-checking bench for ysyx_25020037_lsu_axi_master against a byte-lane reference model.
// The watchdog scenario runs only when YSYX_25020037_AXI_TIMEOUT_EN is defined.
module tb_ysyx_25020037_lsu_axi_master;

   localparam logic [3:0] AXI_ID = 4'h1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic [3:0]  req_wmask;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  awid, wstrb, bid, arid, rid;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_rdata = '0;

   always #5 clk = ~clk;

   ysyx_25020037_lsu_axi_master #(.AXI_ID(AXI_ID), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_size(req_size), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
      end
   endtask

   // Reference lane placement: byte i of the bus carries byte (i - off) of the core data.
   function automatic logic [31:0] laneWdata(input logic [31:0] d, input logic [1:0] off);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(off)) r[i*8 +: 8] = d[(i - int'(off))*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [3:0] laneStrb(input logic [3:0] m, input logic [1:0] off);
      logic [3:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(off)) r[i] = m[i - int'(off)];
      end
      return r;
   endfunction

   function automatic logic [31:0] loadData(input logic [31:0] d, input logic [1:0] off);
      logic [31:0] r = '0;
      for (int j = 0; j < 4; j++) begin
         if (j + int'(off) < 4) r[j*8 +: 8] = d[(j + int'(off))*8 +: 8];
      end
      return r;
   endfunction

   task automatic waitReady();
      int n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("req_ready_idle", req_ready, 1);
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] rd,
                                input logic [1:0] resp, input logic [3:0] id, input logic last,
                                input int d1, input int d2, input int d3, input logic reset_in_b);
      int   lat;
      int   mx;
      logic exp_err;
      waitReady();
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_wdata = wd; req_wmask = wm;
      @(negedge clk);
      lat = 1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
      checkOutput("req_ready_busy", req_ready, 0);
      if (!we) begin
         checkOutput("arvalid_up", arvalid, 1);
         checkOutput("araddr", araddr, addr);
         checkOutput("arsize", arsize, {1'b0, size});
         checkOutput("arid", arid, AXI_ID);
         checkOutput("arlen_arburst", {arlen, arburst}, {8'h00, 2'b01});
         for (int k = 0; k < d1; k++) begin
            @(negedge clk); lat++;
            checkOutput("arvalid_hold", arvalid, 1);
            checkOutput("araddr_hold", araddr, addr);
         end
         arready = 1'b1;
         @(negedge clk); lat++;
         arready = 1'b0;
         checkOutput("arvalid_drop", arvalid, 0);
         checkOutput("rready_up", rready, 1);
         for (int k = 0; k < d2; k++) begin
            @(negedge clk); lat++;
            checkOutput("rready_hold", rready, 1);
            checkOutput("rsp_early", rsp_valid, 0);
         end
         rvalid = 1'b1; rdata = rd; rresp = resp; rid = id; rlast = last;
         @(negedge clk); lat++;
         rvalid = 1'b0; rlast = 1'b0;
         model_rdata = loadData(rd, addr[1:0]);
         exp_err = (resp != 2'b00) || (id != AXI_ID) || !last;
         checkOutput("rd_rsp_valid", rsp_valid, 1);
         checkOutput("rd_rsp_rdata", rsp_rdata, model_rdata);
         checkOutput("rd_rsp_err", rsp_err, exp_err);
         checkOutput("rd_latency", lat, 3 + d1 + d2);
         checkOutput("rready_drop", rready, 0);
      end else begin
         mx = (d1 > d2) ? d1 : d2;
         checkOutput("awvalid_up", awvalid, 1);
         checkOutput("wvalid_up", wvalid, 1);
         checkOutput("awaddr", awaddr, addr);
         checkOutput("awsize", awsize, {1'b0, size});
         checkOutput("wdata", wdata, laneWdata(wd, addr[1:0]));
         checkOutput("wstrb", wstrb, laneStrb(wm, addr[1:0]));
         checkOutput("wlast", wlast, 1);
         checkOutput("awid_awlen", {awid, awlen, awburst}, {AXI_ID, 8'h00, 2'b01});
         for (int k = 0; k <= mx; k++) begin
            awready = (k == d1); wready = (k == d2);
            @(negedge clk); lat++;
            awready = 1'b0; wready = 1'b0;
            checkOutput("awvalid_seq", awvalid, k < d1);
            checkOutput("wvalid_seq", wvalid, k < d2);
            checkOutput("bready_seq", bready, k == mx);
            if (k < d1) checkOutput("awaddr_hold", awaddr, addr);
            if (k < d2) checkOutput("wdata_hold", wdata, laneWdata(wd, addr[1:0]));
         end
         if (reset_in_b) begin
            #2 rst_n = 1'b0;
            #1;
            checkOutput("rst_valids", {awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, rsp_err}, 0);
            checkOutput("rst_addr", awaddr | araddr, 0);
            checkOutput("rst_data", wdata | rsp_rdata, 0);
            checkOutput("rst_strb_id", {wstrb, awid, arid}, 0);
            model_rdata = '0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               checkOutput("rst_no_rsp", rsp_valid, 0);
            end
            rst_n = 1'b1;
            return;
         end
         for (int k = 0; k < d3; k++) begin
            @(negedge clk); lat++;
            checkOutput("bready_hold", bready, 1);
            checkOutput("rsp_early", rsp_valid, 0);
         end
         bvalid = 1'b1; bresp = resp; bid = id;
         @(negedge clk); lat++;
         bvalid = 1'b0;
         exp_err = (resp != 2'b00) || (id != AXI_ID);
         checkOutput("wr_rsp_valid", rsp_valid, 1);
         checkOutput("wr_rsp_err", rsp_err, exp_err);
         checkOutput("wr_rsp_rdata", rsp_rdata, model_rdata);
         checkOutput("wr_latency", lat, 3 + mx + d3);
         checkOutput("bready_drop", bready, 0);
      end
      @(negedge clk);
      checkOutput("rsp_pulse_end", rsp_valid, 0);
      checkOutput("req_ready_back", req_ready, 1);
   endtask

   initial begin
      logic        r_we, r_last;
      logic [31:0] r_addr, r_wd, r_rd;
      logic [1:0]  r_size, r_resp;
      logic [3:0]  r_wm, r_id;
      req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wmask = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
      arready = 0; rvalid = 0; rresp = 0; rdata = 0; rlast = 0; rid = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset_valids", {awvalid, wvalid, bready, arvalid, rready, req_ready, rsp_valid, rsp_err}, 0);
      checkOutput("reset_addr", awaddr | araddr, 0);
      checkOutput("reset_data", wdata | rsp_rdata, 0);
      checkOutput("reset_strb_id", {wstrb, awid, arid, wlast}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 32'h80000004, 2'd2, 0, 0, 32'hDEADBEEF, 2'b00, 4'h1, 1, 0, 0, 0, 0);
      applyStimulus(0, 32'h80000003, 2'd0, 0, 0, 32'hAB000000, 2'b00, 4'h1, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h80000002, 2'd1, 32'h00001234, 4'h3, 0, 2'b00, 4'h1, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h80000002, 2'd1, 32'h00001234, 4'h3, 0, 2'b00, 4'h1, 0, 0, 2, 1, 0);
      applyStimulus(1, 32'h80000101, 2'd0, 32'h000000C3, 4'h1, 0, 2'b00, 4'h1, 0, 3, 1, 0, 0);
      applyStimulus(0, 32'h80000008, 2'd2, 0, 0, 32'h01234567, 2'b10, 4'h1, 1, 5, 1, 0, 0);
      applyStimulus(1, 32'h80000010, 2'd2, 32'hCAFEF00D, 4'hF, 0, 2'b00, 4'h1, 0, 0, 0, 0, 1);
      applyStimulus(0, 32'h80000012, 2'd1, 0, 0, 32'h5566A1B2, 2'b00, 4'h1, 1, 1, 2, 0, 0);

      waitReady();
      rvalid = 1'b1; bvalid = 1'b1; rid = AXI_ID; bid = AXI_ID; rlast = 1'b1;
      @(negedge clk);
      rvalid = 1'b0; bvalid = 1'b0; rlast = 1'b0;
      checkOutput("stray_rsp_ignored", rsp_valid, 0);
      checkOutput("stray_readies", {rready, bready}, 0);
      checkOutput("stray_idle_ready", req_ready, 1);

      for (int t = 0; t < 24; t++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_addr = $urandom;
         r_size = 2'($urandom_range(0, 2));
         r_wd   = $urandom;
         r_wm   = 4'($urandom_range(0, 15));
         r_rd   = $urandom;
         r_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         r_id   = ($urandom_range(0, 5) == 0) ? 4'h2 : AXI_ID;
         r_last = ($urandom_range(0, 5) != 0);
         applyStimulus(r_we, r_addr, r_size, r_wd, r_wm, r_rd, r_resp, r_id, r_last,
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end

`ifdef YSYX_25020037_AXI_TIMEOUT_EN
      begin
         int at = 0;
         waitReady();
         req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80000020; req_size = 2'd2;
         @(negedge clk);
         req_valid = 1'b0;
         for (int n = 1; n <= 40; n++) begin
            if (rsp_valid === 1'b1 && at == 0) begin
               at = n;
               checkOutput("to_arvalid_drop", arvalid, 0);
               checkOutput("to_rsp_err", rsp_err, 1);
               checkOutput("to_rsp_rdata", rsp_rdata, 0);
            end
            @(negedge clk);
         end
         checkOutput("to_latency", at, 17);
         model_rdata = '0;
         applyStimulus(0, 32'h80000024, 2'd2, 0, 0, 32'h0BADF00D, 2'b00, 4'h1, 1, 0, 0, 0, 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_25020037_lsu_axi_master.md
Name: ysyx_25020037_lsu_axi_master

Overview:
AXI4 initiator that turns the core's single-request load/store port into single-beat AXI4 read and write transactions. It sits between the LSU/IFU arbiter and the memory side, and drives the SRAM responder and the crossbar.
- One outstanding transaction at a time.
- Byte-lane alignment is done here, so the core sees LSB-aligned data.

Parameters:
AXI_ID, 4'h1, ID driven on arid/awid and expected on rid/bid
TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word
req_wdata  in  32  store data, LSB-aligned
req_wmask  in  4  store byte mask, LSB-aligned
rsp_valid  out  1  response valid, one-cycle pulse
rsp_rdata  out  32  load data, LSB-aligned
rsp_err  out  1  bus error on this response
awvalid/awready/awaddr[31:0]/awid[3:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]  AXI4 AW (awready in, rest out)
wvalid/wready/wdata[31:0]/wstrb[3:0]/wlast  AXI4 W (wready in, rest out)
bvalid/bready/bresp[1:0]/bid[3:0]  AXI4 B (bready out, rest in)
arvalid/arready/araddr[31:0]/arid[3:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]  AXI4 AR (arready in, rest out)
rvalid/rready/rresp[1:0]/rdata[31:0]/rlast/rid[3:0]  AXI4 R (rready out, rest in)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All valids, bready, rready, req_ready, rsp_valid and rsp_err are 0. All addr/data/strb/id outputs are 0. Reset mid-transaction abandons the transaction immediately; no rsp_valid is produced.
- Constant outputs: awlen = arlen = 0; awburst = arburst = 2'b01; wlast = 1 whenever wvalid = 1; awid = arid = AXI_ID.
- req_ready = 1 only in IDLE. On req_valid & req_ready the block latches addr, size, we, wdata and wmask.
- off = addr[1:0]. Outgoing address is the unmodified req_addr. axsize = {1'b0, req_size}.
- wdata = req_wdata << (off*8). wstrb = (req_wmask << off) truncated to 4 bits.
- States: IDLE, AR, R, AW_W, B.
  - IDLE -> AR on a load accept; arvalid=1 from the next cycle.
  - AR: hold araddr and arvalid until arready (registered handshake). Then arvalid=0, rready=1, go to R.
  - R: on rvalid & rready, capture rdata >> (off*8) into rsp_rdata and assert rsp_valid for one cycle. rsp_err = (rresp != 0) | (rid != AXI_ID) | !rlast. Clear rready and return to IDLE.
  - IDLE -> AW_W on a store accept; awvalid=1 and wvalid=1 together.
  - AW_W: each channel drops its own valid at its handshake, and handshakes may occur in either order or the same cycle. When both are done, bready=1 and go to B.
  - B: on bvalid & bready, rsp_valid=1 and rsp_err = (bresp != 0) | (bid != AXI_ID). rsp_rdata is unchanged. Clear bready and return to IDLE.
- Valid/payload stability: once asserted, arvalid, awvalid and wvalid are never deasserted before their handshake, and their payload does not change.
- Latency with a zero-wait responder: load is 3 cycles from accept to rsp_valid. Store is 3 cycles when AW and W complete together.
- rsp_valid is never asserted in the same cycle as req_ready. A new request can be accepted in the cycle after rsp_valid.
- Responses arriving in the wrong state (e.g. rvalid while in IDLE) are ignored; rready and bready are 0 outside R and B.

Optional Feature:
YSYX_25020037_AXI_TIMEOUT_EN
- Defined: a counter clears on entry to AR/AW_W and increments every cycle in AR, R, AW_W and B. On reaching TIMEOUT_CYCLES-1, all valids and readies are dropped, rsp_valid=1 and rsp_err=1 are pulsed, rsp_rdata=0, and the FSM returns to IDLE.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Load word at 0x80000004, responder returns rdata=0xDEADBEEF, rresp=0, rid=1, rlast=1 -> araddr=0x80000004, arsize=2, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
- Load byte at 0x80000003, rdata=0xAB000000 -> arsize=0, rsp_rdata=0x000000AB.
- Store half at 0x80000002, wdata=0x1234, mask=0x3 -> wdata=0x12340000, wstrb=0xC, wlast=1. Then force awready 2 cycles before wready: AW drops first, B is entered only after W completes.
- Responder stalls arready for 5 cycles -> arvalid and araddr stay stable throughout. Then rresp=2'b10 -> rsp_err=1.
- Pull rst_n low while in B -> all outputs 0 immediately, no rsp_valid. After release, a new load completes normally.
- With YSYX_25020037_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16, never assert arready -> rsp_valid with rsp_err=1 exactly 16 cycles after entering AR, and arvalid drops the same cycle.
